// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing generator (640x480@60 defaults).
package vga_timing_pkg;

    typedef enum logic {
        ACTIVE_LOW  = 1'b0,
        ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with registered sync and a next-position active decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int        ACTIVE = DEF_H_ACTIVE,
    parameter int        FP     = DEF_H_FP,
    parameter int        SYNC   = DEF_H_SYNC,
    parameter int        BP     = DEF_H_BP,
    parameter sync_pol_e POL    = ACTIVE_LOW,
    parameter int        CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W:0] SYNC_BEG = (CNT_W+1)'(ACTIVE + FP);
    localparam logic [CNT_W:0] SYNC_END = (CNT_W+1)'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_nxt;
    logic             sync_hit;

    assign wrap = step && (count == CNT_W'(TOTAL - 1));

    always_comb begin
        count_nxt = count;
        if (step)
            count_nxt = wrap ? '0 : count + 1'b1;
    end

    // Decodes look at the next count so registered outputs line up with the counter.
    assign active   = ({1'b0, count_nxt} < (CNT_W+1)'(ACTIVE));
    assign sync_hit = ({1'b0, count_nxt} >= SYNC_BEG) && ({1'b0, count_nxt} < SYNC_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= ~POL;
        end else if (step) begin
            count <= count_nxt;
            sync  <= sync_hit ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. Define VGA_TIMING_MEM_ADDR_EN to build the
// linear video-memory address counter; otherwise oVmemAddress is tied to 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = $clog2(DEF_H_TOTAL > DEF_V_TOTAL ? DEF_H_TOTAL : DEF_V_TOTAL),
    parameter int ADDR_W   = 19
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iPixelEn,
    output logic              oHS,
    output logic              oVS,
    output logic              oActive,
    output logic              oFrameStart,
    output logic [CNT_W-1:0]  oColumn,
    output logic [CNT_W-1:0]  oRow,
    output logic [ADDR_W-1:0] oVmemAddress
);

    logic h_wrap, v_wrap, h_act_nxt, v_act_nxt;
    logic frame_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(sync_pol_e'(HS_POL)), .CNT_W(CNT_W)
    ) u_h (
        .clk(Clock), .rst_n(Reset), .step(iPixelEn),
        .count(oColumn), .wrap(h_wrap), .sync(oHS), .active(h_act_nxt)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(sync_pol_e'(VS_POL)), .CNT_W(CNT_W)
    ) u_v (
        .clk(Clock), .rst_n(Reset), .step(h_wrap),
        .count(oRow), .wrap(v_wrap), .sync(oVS), .active(v_act_nxt)
    );

    // v_wrap already implies h_wrap, which implies iPixelEn.
    assign frame_wrap = v_wrap;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oActive     <= 1'b1;
            oFrameStart <= 1'b0;
        end else begin
            oFrameStart <= frame_wrap;
            if (iPixelEn)
                oActive <= h_act_nxt && v_act_nxt;
        end
    end

`ifdef VGA_TIMING_MEM_ADDR_EN
    // Counting visible steps reproduces row*H_ACTIVE+col without a multiplier.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            oVmemAddress <= '0;
        else if (frame_wrap)
            oVmemAddress <= '0;
        else if (iPixelEn && h_act_nxt && v_act_nxt)
            oVmemAddress <= oVmemAddress + 1'b1;
    end
`else
    assign oVmemAddress = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x8 frame, with a second instance at inverted sync polarity.
module tb_vga_timing_gen;

    localparam int HT = 14, VT = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iPixelEn = 1'b0;
    logic       hs0, vs0, act0, fs0, hs1, vs1, act1, fs1;
    logic [3:0] col0, row0, col1, row1;
    logic [4:0] addr0, addr1;

    always #5 Clock = ~Clock;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .ADDR_W(5)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
        .oHS(hs0), .oVS(vs0), .oActive(act0), .oFrameStart(fs0),
        .oColumn(col0), .oRow(row0), .oVmemAddress(addr0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .ADDR_W(5)
    ) dut_p (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
        .oHS(hs1), .oVS(vs1), .oActive(act1), .oFrameStart(fs1),
        .oColumn(col1), .oRow(row1), .oVmemAddress(addr1)
    );

    typedef struct {
        int col, row, addr;
        bit hs, vs, act, fs;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_bad = 0;
    int   m_col = 0, m_row = 0, m_addr = 0;
    bit   m_fs = 0;
    int   fs_seen = 0;

    function automatic exp_t cur();
        exp_t e;
        e.col  = m_col;
        e.row  = m_row;
        e.addr = m_addr;
        e.hs   = !(m_col >= 10 && m_col <= 12);   // active-low HS on cols 10..12
        e.vs   = !(m_row >= 5 && m_row <= 6);     // active-low VS on rows 5..6
        e.act  = (m_col < 8) && (m_row < 4);
        e.fs   = m_fs;
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, got, want);
        end
    endtask

    task automatic step(input bit en);
        @(negedge Clock);
        iPixelEn = en;
        if (en) begin
            m_fs = (m_col == HT-1) && (m_row == VT-1);
            if (m_col == HT-1) begin
                m_col = 0;
                m_row = (m_row == VT-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
`ifdef VGA_TIMING_MEM_ADDR_EN
            if (m_col == 0 && m_row == 0) m_addr = 0;
            else if (m_col < 8 && m_row < 4) m_addr++;
`endif
        end else begin
            m_fs = 0;
        end
        q.push_back(cur());
    endtask

    // Reset falls between clock edges so only an asynchronous reset shows up at the next sample.
    task automatic do_reset();
        @(negedge Clock);
        #2;
        iPixelEn = 1'b0;
        Reset    = 1'b0;
        m_col = 0; m_row = 0; m_addr = 0; m_fs = 0;
        q.push_back(cur());
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock or negedge Reset);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("column", int'(col0), e.col);
                chk("row", int'(row0), e.row);
                chk("hs", int'(hs0), int'(e.hs));
                chk("vs", int'(vs0), int'(e.vs));
                chk("active", int'(act0), int'(e.act));
                chk("framestart", int'(fs0), int'(e.fs));
                chk("vmem_addr", int'(addr0), e.addr);
                chk("pol1_column", int'(col1), e.col);
                chk("pol1_row", int'(row1), e.row);
                chk("pol1_hs", int'(hs1), int'(!e.hs));
                chk("pol1_vs", int'(vs1), int'(!e.vs));
                chk("pol1_active", int'(act1), int'(e.act));
                chk("pol1_framestart", int'(fs1), int'(e.fs));
                chk("pol1_vmem_addr", int'(addr1), e.addr);
                if (fs0) fs_seen++;
            end
        end
    end

    initial begin : driver
        int fs_before;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        do_reset();
        repeat (3) step(1'b0);

        // First line, then the rest of the frame: wrap lands on the 112th enable.
        repeat (HT) step(1'b1);
        fs_before = fs_seen;
        repeat (HT*VT - HT) step(1'b1);
        step(1'b0);
        @(negedge Clock);
        chk("frame_strobes_per_frame", fs_seen - fs_before, 1);

        // Half-rate enable: one full frame in 224 clocks.
        fs_before = fs_seen;
        repeat (HT*VT) begin
            step(1'b1);
            step(1'b0);
        end
        @(negedge Clock);
        chk("frame_strobes_half_rate", fs_seen - fs_before, 1);

        // Reach (11,6), then hit reset mid-frame and resume from (0,0).
        repeat (6*HT + 11) step(1'b1);
        do_reset();
        repeat (HT + 3) step(1'b1);
        repeat (2) step(1'b0);

        @(negedge Clock);
        @(negedge Clock);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640-column controller.
- Generates horizontal and vertical counters, HS/VS with configurable widths and polarities, a display-active flag, a frame-start strobe and a linear video-memory address.
- Sits between the pixel-clock-enable source and the video memory / colour output stage.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HS asserted level (0 = active-low)
- VS_POL, 0, VS asserted level
- CNT_W, 10, column/row counter width; must hold H_TOTAL-1 and V_TOTAL-1
- ADDR_W, 19, memory address width; must hold H_ACTIVE*V_ACTIVE-1

Ports:
- Clock  input  1  system clock
- Reset  input  1  asynchronous, active-low reset
- iPixelEn  input  1  pixel-rate enable; all state advances only when high
- oHS  output  1  horizontal sync
- oVS  output  1  vertical sync
- oActive  output  1  high when current pixel is in the visible area
- oFrameStart  output  1  one-Clock strobe at frame wrap
- oColumn  output  CNT_W  current column, 0..H_TOTAL-1
- oRow  output  CNT_W  current row, 0..V_TOTAL-1
- oVmemAddress  output  ADDR_W  linear address of current visible pixel

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset low, asynchronously:
  - oColumn=0, oRow=0, oVmemAddress=0, oFrameStart=0.
  - oActive=1 (decode of position 0,0).
  - oHS=~HS_POL, oVS=~VS_POL (both inactive).
- Column counter:
  - Advances on each Clock edge with iPixelEn=1.
  - Wraps from H_TOTAL-1 to 0; no change when iPixelEn=0.
- Row counter:
  - Increments only when column wraps.
  - Wraps from V_TOTAL-1 to 0 on a simultaneous column wrap.
- Output registration:
  - All outputs are registered and computed from the next counter values.
  - oHS, oVS, oActive and oVmemAddress are therefore cycle-aligned with oColumn/oRow, with no combinational glitches.
- Decode:
  - oHS asserted iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
  - oVS asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC.
  - oActive = (col < H_ACTIVE) && (row < V_ACTIVE).
- oFrameStart: high for exactly one Clock cycle, the cycle in which the counters become (0,0) via wrap. It is not asserted on reset release.
- iPixelEn held low: all outputs hold, and oFrameStart drops to 0 after one cycle.
- Reset asserted mid-frame: immediate return to the reset values above; the first enable after release moves to (1,0).

Optional Feature:
- Macro: VGA_TIMING_MEM_ADDR_EN.
- Defined:
  - oVmemAddress increments by 1 on every enabled step that leaves the counters in the visible area, and holds during blanking.
  - It is 0 at (0,0), so at visible pixels it equals row*H_ACTIVE+col.
  - No multiplier is used.
- Undefined: oVmemAddress is tied to 0 and the address register is not built.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants;
  - localparam computation of H_TOTAL/V_TOTAL;
  - a sync-polarity enum (ACTIVE_LOW=0, ACTIVE_HIGH=1).
- Sub-module vga_axis_counter is instantiated twice (horizontal, vertical). It provides:
  - parametrised active/FP/sync/BP/polarity;
  - inputs: step enable;
  - outputs: count, wrap, registered sync, active.

Test Plan:
- Bench parameters: H = 8/2/3/1 (H_TOTAL=14), V = 4/1/2/1 (V_TOTAL=8), polarities 0. Frame = 112 enables.
- Reset then 14 enables → oColumn 1..13,0; oHS=0 exactly for col 10..12; oRow becomes 1 on 14th enable.
- 112 consecutive enables → oFrameStart high exactly once, on the 112th enable, with oColumn=0, oRow=0; oVS=0 exactly for rows 5..6.
- iPixelEn toggling 1/0 every Clock → counters advance every second Clock; frame completes after 224 Clocks; oFrameStart is one Clock wide.
- VGA_TIMING_MEM_ADDR_EN defined, full frame → oVmemAddress at (col 3, row 2) = 19; holds 31 through blanking; 0 at next frame start.
- Reset asserted asynchronously at (col 11, row 6) → same-cycle oHS=1, oVS=1, counters 0, oActive=1; after release resumes from (0,0).
- HS_POL=1, VS_POL=1 rerun → sync waveforms inverted; reset level of oHS/oVS = 0.
